// File: rtl/lsu_pkg.sv
// Load/store unit shared types: funct3 codes, FSM states,
// latched request bundle and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    RESP
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // 1 = misaligned, unknown funct3, or unsigned store
  function automatic logic req_bad(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = |off;
      F3_BU:   bad = we;
      F3_HU:   bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane extract/extend for loads and lane merge for SB/SH.
// Ports: funct3, off (addr[1:0]), word (memory), wdata -> load_data, merged.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    load_data = word;
    unique case (1'b1)
      (funct3 == F3_B):  load_data = {{24{b[7]}}, b};
      (funct3 == F3_BU): load_data = {24'd0, b};
      (funct3 == F3_H):  load_data = {{16{h[15]}}, h};
      (funct3 == F3_HU): load_data = {16'd0, h};
      default:           load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    unique case (1'b1)
      (funct3 == F3_B):
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      (funct3 == F3_H):
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      default:
        merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store initiator for a word-only memory (RMW for SB/SH).
// Ports: req_* in, rsp_* out, mem_* to the data memory, clk/rst sync.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int MEMORY_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [WORD_LENGTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic [MEMORY_SIZE-1:0] mem_address,
  output logic [MEMORY_SIZE-1:0] mem_write_add,
  output logic [WORD_LENGTH-1:0] mem_write_data,
  output logic                   mem_write_enable,
  output logic                   mem_read_enable,
  input  logic [WORD_LENGTH-1:0] mem_data_out
);

  lsu_state_e             state, state_n;
  lsu_req_t               req;
  logic [WORD_LENGTH-1:0] merged_q;
  logic [31:0]            ld_data;
  logic [31:0]            mg_data;
  logic                   bad;
  logic [MEMORY_SIZE-1:0] widx;

  assign bad  = req_bad(req_we, req_funct3, req_addr[1:0]);
  assign widx = MEMORY_SIZE'(req.addr[31:2]);

  assign mem_address    = widx;
  assign mem_write_add  = widx;
  assign mem_write_data = merged_q;

  lsu_align u_align (
    .funct3    (req.funct3),
    .off       (req.addr[1:0]),
    .word      (mem_data_out),
    .wdata     (req.wdata),
    .load_data (ld_data),
    .merged    (mg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n          = state;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad)                     state_n = RESP;
          else if (!req_we)            state_n = LOAD;
          else if (req_funct3 == F3_W) state_n = WRITE;
          else                         state_n = RMW_READ;
        end
      end
      LOAD: begin
        mem_read_enable = 1'b1;
        state_n         = RESP;
      end
      RMW_READ: begin
        mem_read_enable = 1'b1;
        state_n         = WRITE;
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        state_n          = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Strobes must drop the moment reset rises, even mid-access
    if (rst) begin
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req       <= '0;
      merged_q  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (req_valid) begin
            req.we     <= req_we;
            req.funct3 <= req_funct3;
            req.addr   <= req_addr;
            req.wdata  <= req_wdata;
            // SW writes wdata as-is; SB/SH overwrite this in RMW_READ
            merged_q   <= req_wdata;
            rsp_rdata  <= '0;
            rsp_err    <= bad;
          end
        LOAD:     rsp_rdata <= ld_data;
        RMW_READ: merged_q  <= mg_data;
        default: ;
      endcase
    end
  end

endmodule
